// File: rtl/bundle_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bundle_packer
// Description : Packs an in-order stream of 5-bit opcodes into 4-slot VLIW
//               bundles {A0, A1, M, LS}, NOP-filling empty slots, and presents
//               closed bundles on a one-entry valid/ready output register.
//               Optional statistics counters: define BUNDLE_PACKER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bundle_packer #(
    parameter int FLUSH_CYCLES = 8,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        op_in,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic              flush,
    output logic [19:0]       bundle_out,
    output logic              bundle_valid,
    input  logic              bundle_ready,
    output logic              err
`ifdef BUNDLE_PACKER_STATS_EN
    ,
    output logic [CNT_W-1:0]  bundles_emitted,
    output logic [CNT_W-1:0]  nops_inserted
`endif
);

    localparam logic [4:0]      C_NOP_ALU   = 5'b00000;
    localparam logic [4:0]      C_NOP_MUL   = 5'b01100;
    localparam logic [4:0]      C_NOP_LS    = 5'b10010;
    // Slot index 3..0 maps to A0, A1, M, LS so the packed array is the bundle layout.
    localparam logic [3:0][4:0] C_NOP_FILL  = {C_NOP_ALU, C_NOP_ALU, C_NOP_MUL, C_NOP_LS};
    localparam int              C_IDLE_W    = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [C_IDLE_W-1:0] C_IDLE_LIMIT = C_IDLE_W'(FLUSH_CYCLES);

    logic [3:0][4:0]     r_slot;
    logic [3:0]          r_occ;
    logic [19:0]         r_out;
    logic                r_valid;
    logic                r_pend;
    logic                r_err;
    logic [C_IDLE_W-1:0] r_idle;

    logic                w_is_alu;
    logic                w_is_mul;
    logic                w_is_ls;
    logic                w_is_legal;
    logic                w_fits;
    logic                w_full;
    logic                w_busy;
    logic                w_out_free;
    logic                w_accept;
    logic                w_legal_acc;
    logic                w_conflict;
    logic                w_timeout;
    logic                w_close;
    logic [3:0][4:0]     w_filled;
    logic [3:0][4:0]     w_nxt_slot;
    logic [3:0]          w_nxt_occ;

    always_comb begin
        w_is_alu   = (op_in >= 5'd1) && (op_in <= 5'd11);
        w_is_mul   = (op_in == 5'd13) || (op_in == 5'd14);
        w_is_ls    = (op_in == 5'd16) || (op_in == 5'd17);
        w_is_legal = w_is_alu | w_is_mul | w_is_ls;
        w_fits     = (w_is_alu & ~(r_occ[3] & r_occ[2]))
                   | (w_is_mul & ~r_occ[1])
                   | (w_is_ls  & ~r_occ[0]);
    end

    assign w_full      = &r_occ;
    assign w_busy      = |r_occ;
    assign w_out_free  = ~r_valid | bundle_ready;
    assign op_ready    = ~w_is_legal | (w_fits & ~w_full) | w_out_free;
    assign w_accept    = op_valid & op_ready;
    assign w_legal_acc = w_accept & w_is_legal;
    assign w_conflict  = w_legal_acc & ~w_fits;
    assign w_timeout   = (FLUSH_CYCLES != 0) && (r_idle == C_IDLE_LIMIT);
    assign w_close     = w_busy & (w_full | w_conflict | r_pend | w_timeout) & w_out_free;

    for (genvar gi = 0; gi < 4; gi++) begin : g_fill
        assign w_filled[gi] = r_occ[gi] ? r_slot[gi] : C_NOP_FILL[gi];
    end

    // An op accepted on a closing edge starts the next build rather than joining the closed one.
    always_comb begin
        w_nxt_occ  = w_close ? 4'b0000 : r_occ;
        w_nxt_slot = w_close ? C_NOP_FILL : r_slot;
        if (w_legal_acc) begin
            if (w_is_alu) begin
                if (!w_nxt_occ[3]) begin
                    w_nxt_occ[3]  = 1'b1;
                    w_nxt_slot[3] = op_in;
                end else begin
                    w_nxt_occ[2]  = 1'b1;
                    w_nxt_slot[2] = op_in;
                end
            end else if (w_is_mul) begin
                w_nxt_occ[1]  = 1'b1;
                w_nxt_slot[1] = op_in;
            end else begin
                w_nxt_occ[0]  = 1'b1;
                w_nxt_slot[0] = op_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot  <= C_NOP_FILL;
            r_occ   <= 4'b0000;
            r_out   <= C_NOP_FILL;
            r_valid <= 1'b0;
            r_pend  <= 1'b0;
            r_err   <= 1'b0;
            r_idle  <= '0;
        end else begin
            r_slot <= w_nxt_slot;
            r_occ  <= w_nxt_occ;
            r_err  <= w_accept & ~w_is_legal & ~(op_in == 5'd0 || op_in == 5'd12 || op_in == 5'd18);

            if (w_close) begin
                r_out   <= w_filled;
                r_valid <= 1'b1;
            end else if (bundle_ready) begin
                r_valid <= 1'b0;
            end

            // A flush on an empty build with nothing arriving is simply discarded.
            if (w_close) begin
                r_pend <= flush & w_legal_acc;
            end else if (flush & (w_busy | w_legal_acc)) begin
                r_pend <= 1'b1;
            end

            if (w_close | w_legal_acc) begin
                r_idle <= '0;
            end else if (w_busy && (r_idle != C_IDLE_LIMIT)) begin
                r_idle <= r_idle + 1'b1;
            end
        end
    end

    assign bundle_out   = r_out;
    assign bundle_valid = r_valid;
    assign err          = r_err;

`ifdef BUNDLE_PACKER_STATS_EN
    logic [CNT_W-1:0] r_bundles;
    logic [CNT_W-1:0] r_nops;
    logic [2:0]       w_empty_cnt;

    assign w_empty_cnt = 3'(~r_occ[0]) + 3'(~r_occ[1]) + 3'(~r_occ[2]) + 3'(~r_occ[3]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bundles <= '0;
            r_nops    <= '0;
        end else if (w_close) begin
            r_bundles <= r_bundles + 1'b1;
            r_nops    <= r_nops + CNT_W'(w_empty_cnt);
        end
    end

    assign bundles_emitted = r_bundles;
    assign nops_inserted   = r_nops;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bundle_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_bundle_packer
// Description : Directed scoreboard bench for bundle_packer; expected bundles
//               are queued at stimulus time and checked by an output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bundle_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  op_in;
    logic        op_valid;
    logic        op_ready;
    logic        flush;
    logic [19:0] bundle_out;
    logic        bundle_valid;
    logic        bundle_ready;
    logic        err;
`ifdef BUNDLE_PACKER_STATS_EN
    logic [15:0] bundles_emitted;
    logic [15:0] nops_inserted;
`endif

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [19:0] exp_q[$];

    localparam logic [19:0] C_RESET_OUT = {5'b00000, 5'b00000, 5'b01100, 5'b10010};
    localparam logic [19:0] C_HELD      = {5'b00000, 5'b00000, 5'b01101, 5'b10010};

    bundle_packer #(
        .FLUSH_CYCLES (8),
        .CNT_W        (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .op_in           (op_in),
        .op_valid        (op_valid),
        .op_ready        (op_ready),
        .flush           (flush),
        .bundle_out      (bundle_out),
        .bundle_valid    (bundle_valid),
        .bundle_ready    (bundle_ready),
        .err             (err)
`ifdef BUNDLE_PACKER_STATS_EN
        ,
        .bundles_emitted (bundles_emitted),
        .nops_inserted   (nops_inserted)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every transfer on the output handshake must match the queue head.
    always @(negedge clk) begin
        if (rst_n && bundle_valid && bundle_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_bundle: got %0h, expected no bundle", bundle_out);
            end else begin
                check("bundle", {12'd0, bundle_out}, {12'd0, exp_q.pop_front()});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_op(input logic [4:0] op);
        int waited;
        waited   = 0;
        op_in    = op;
        op_valid = 1'b1;
        @(negedge clk);
        while (!op_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!op_ready) begin
            n_checks++;
            n_fails++;
            $display("FAIL send_timeout: op %0h got op_ready 0, expected 1 within 50 cycles", op);
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    initial begin
        op_in        = 5'd0;
        op_valid     = 1'b0;
        flush        = 1'b0;
        bundle_ready = 1'b1;
        rst_n        = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(bundle_valid), 32'd0);
        check("rst_out", 32'(bundle_out), 32'(C_RESET_OUT));
        check("rst_err", 32'(err), 32'd0);
        check("rst_op_ready", 32'(op_ready), 32'd1);
`ifdef BUNDLE_PACKER_STATS_EN
        check("rst_bundles", 32'(bundles_emitted), 32'd0);
        check("rst_nops", 32'(nops_inserted), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Four fitting ops fill every slot and close on the following edge
        exp_q.push_back({5'b00001, 5'b00010, 5'b01101, 5'b10001});
        send_op(5'b00001);
        send_op(5'b00010);
        send_op(5'b01101);
        send_op(5'b10001);
        @(negedge clk);
        check("full_lat_pre", 32'(bundle_valid), 32'd0);
        @(negedge clk);
        check("full_lat_valid", 32'(bundle_valid), 32'd1);
        @(posedge clk);
        #1;

        // MUL conflict closes at once; lone MUL closes after the idle timeout
        exp_q.push_back({5'b00000, 5'b00000, 5'b01101, 5'b10010});
        exp_q.push_back({5'b00000, 5'b00000, 5'b01110, 5'b10010});
        send_op(5'b01101);
        send_op(5'b01110);
        repeat (9) @(negedge clk);
        check("timeout_pre", 32'(bundle_valid), 32'd0);
        @(negedge clk);
        check("timeout_valid", 32'(bundle_valid), 32'd1);
`ifdef BUNDLE_PACKER_STATS_EN
        check("timeout_nops", 32'(nops_inserted), 32'd6);
        check("timeout_bundles", 32'(bundles_emitted), 32'd3);
`endif
        @(posedge clk);
        #1;

        // Flush closes one edge after it is sampled; empty flush emits nothing
        exp_q.push_back({5'b00000, 5'b00000, 5'b01100, 5'b10000});
        send_op(5'b10000);
        flush_pulse();
        @(negedge clk);
        check("flush_pre", 32'(bundle_valid), 32'd0);
        @(negedge clk);
        check("flush_valid", 32'(bundle_valid), 32'd1);
        @(posedge clk);
        #1;
        flush_pulse();
        repeat (4) @(negedge clk);
        check("empty_flush", 32'(bundle_valid), 32'd0);
        @(posedge clk);
        #1;

        // Backpressure: held bundle, third ALU op stalls until the consumer frees it
        bundle_ready = 1'b0;
        exp_q.push_back(C_HELD);
        send_op(5'b01101);
        flush_pulse();
        repeat (3) @(negedge clk);
        check("bp_held_valid", 32'(bundle_valid), 32'd1);
        check("bp_held_out", 32'(bundle_out), 32'(C_HELD));
        @(posedge clk);
        #1;
        send_op(5'b00011);
        send_op(5'b00100);
        op_in    = 5'b00101;
        op_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_op_ready_low", 32'(op_ready), 32'd0);
            check("bp_out_stable", 32'(bundle_out), 32'(C_HELD));
        end
        @(posedge clk);
        #1;
        bundle_ready = 1'b1;
        exp_q.push_back({5'b00011, 5'b00100, 5'b01100, 5'b10010});
        @(negedge clk);
        check("bp_op_ready_high", 32'(op_ready), 32'd1);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        exp_q.push_back({5'b00101, 5'b00000, 5'b01100, 5'b10010});
        flush_pulse();
        repeat (3) @(negedge clk);
        check("bp_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;

        // Illegal op pulses err; NOP op is accepted silently; neither uses a slot
        op_in    = 5'b11000;
        op_valid = 1'b1;
        @(negedge clk);
        check("illegal_ready", 32'(op_ready), 32'd1);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        @(negedge clk);
        check("illegal_err_pulse", 32'(err), 32'd1);
        @(negedge clk);
        check("illegal_err_clear", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        op_in    = 5'b01100;
        op_valid = 1'b1;
        @(negedge clk);
        check("nop_ready", 32'(op_ready), 32'd1);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        @(negedge clk);
        check("nop_no_err", 32'(err), 32'd0);
        repeat (12) @(negedge clk);
        check("nop_no_bundle", 32'(bundle_valid), 32'd0);
`ifdef BUNDLE_PACKER_STATS_EN
        check("stats_bundles", 32'(bundles_emitted), 32'd7);
        check("stats_nops", 32'(nops_inserted), 32'd17);
`endif
        @(posedge clk);
        #1;

        // Asynchronous reset mid-build discards held output and partial build
        bundle_ready = 1'b0;
        send_op(5'b01101);
        flush_pulse();
        repeat (3) @(negedge clk);
        check("rst_mid_held", 32'(bundle_valid), 32'd1);
        @(posedge clk);
        #1;
        send_op(5'b00001);
        send_op(5'b10001);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(bundle_valid), 32'd0);
        check("rst_mid_out", 32'(bundle_out), 32'(C_RESET_OUT));
        check("rst_mid_op_ready", 32'(op_ready), 32'd1);
`ifdef BUNDLE_PACKER_STATS_EN
        check("rst_mid_bundles", 32'(bundles_emitted), 32'd0);
`endif
        @(negedge clk);
        rst_n        = 1'b1;
        bundle_ready = 1'b1;
        repeat (15) @(negedge clk);
        check("rst_mid_no_bundle", 32'(bundle_valid), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
